// File: rtl/carry_select_pipe.sv
// carry_select_pipe
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// The operands are split into NB = WIDTH/BLK blocks. The first stage forms
// both carry candidates for every block and resolves block 0 with the
// carry-in. Each later stage resolves one more block, so there is one
// pipeline stage per block and one new operation can be accepted per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous flush of all in-flight operations
//   in_valid   operation offered
//   in_ready   operation accepted when in_valid && in_ready
//   in_a/in_b  operands (WIDTH bits)
//   in_cin     carry-in (in subtract mode 1 = no borrow)
//   in_sub     0: a + b + cin, 1: a + ~b + cin
//   out_valid  result present
//   out_ready  consumer accepts when out_valid && out_ready
//   out_sum    result (WIDTH bits)
//   out_cout   carry out of the MSB
//   out_ovf    two's-complement signed overflow
module carry_select_pipe #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NB = WIDTH / BLK;

   // Global stall: every stage advances together, or none does.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic [WIDTH-1:0] be;
   assign be = in_sub ? ~in_b : in_b;

   // Per-block candidates for the incoming operation.
   logic [BLK:0] in_c0 [NB];
   logic [BLK:0] in_c1 [NB];

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_cand
         assign in_c0[gi] = {1'b0, in_a[gi*BLK +: BLK]} + {1'b0, be[gi*BLK +: BLK]};
         assign in_c1[gi] = in_c0[gi] + {{BLK{1'b0}}, 1'b1};
      end
   endgenerate

   // Block 0 is resolved straight away with the external carry-in.
   logic [BLK:0] blk0_res;
   assign blk0_res = in_cin ? in_c1[0] : in_c0[0];

   // Stage registers, index 0 = first stage, NB-1 = output stage.
   logic             valid_reg  [NB];
   logic [WIDTH-1:0] sum_reg    [NB];
   logic             carry_reg  [NB];
   logic             a_msb_reg  [NB];
   logic             be_msb_reg [NB];
   logic [BLK:0]     cand0_reg  [NB][NB];
   logic [BLK:0]     cand1_reg  [NB][NB];

   logic [WIDTH-1:0] sum_next   [NB];
   logic             carry_next [NB];

   // Stage i picks the candidate for block i using the carry that stage i-1
   // produced; lower blocks already resolved pass through untouched.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         sum_next[i]   = '0;
         carry_next[i] = 1'b0;
      end
      sum_next[0][BLK-1:0] = blk0_res[BLK-1:0];
      carry_next[0]        = blk0_res[BLK];
      for (int i = 1; i < NB; i++) begin
         sum_next[i] = sum_reg[i-1];
         sum_next[i][i*BLK +: BLK] = carry_reg[i-1] ? cand1_reg[i-1][i][BLK-1:0]
                                                    : cand0_reg[i-1][i][BLK-1:0];
         carry_next[i] = carry_reg[i-1] ? cand1_reg[i-1][i][BLK]
                                        : cand0_reg[i-1][i][BLK];
      end
   end

   // Valid bits: flush wins over advance; the accept in a flush cycle is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) valid_reg[i] <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < NB; i++) valid_reg[i] <= 1'b0;
      end else if (en) begin
         valid_reg[0] <= in_valid;
         for (int i = 1; i < NB; i++) valid_reg[i] <= valid_reg[i-1];
      end
   end

   // Data path registers. Contents behind a cleared valid bit are don't-care.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            sum_reg[i]    <= '0;
            carry_reg[i]  <= 1'b0;
            a_msb_reg[i]  <= 1'b0;
            be_msb_reg[i] <= 1'b0;
            for (int k = 0; k < NB; k++) begin
               cand0_reg[i][k] <= '0;
               cand1_reg[i][k] <= '0;
            end
         end
      end else if (en) begin
         for (int i = 0; i < NB; i++) begin
            sum_reg[i]   <= sum_next[i];
            carry_reg[i] <= carry_next[i];
         end
         a_msb_reg[0]  <= in_a[WIDTH-1];
         be_msb_reg[0] <= be[WIDTH-1];
         for (int k = 0; k < NB; k++) begin
            cand0_reg[0][k] <= in_c0[k];
            cand1_reg[0][k] <= in_c1[k];
         end
         for (int i = 1; i < NB; i++) begin
            a_msb_reg[i]  <= a_msb_reg[i-1];
            be_msb_reg[i] <= be_msb_reg[i-1];
            for (int k = 0; k < NB; k++) begin
               cand0_reg[i][k] <= cand0_reg[i-1][k];
               cand1_reg[i][k] <= cand1_reg[i-1][k];
            end
         end
      end
   end

   assign out_valid = valid_reg[NB-1];
   assign out_sum   = sum_reg[NB-1];
   assign out_cout  = carry_reg[NB-1];
   // Overflow: operands of equal sign producing a result of the other sign.
   assign out_ovf   = (a_msb_reg[NB-1] == be_msb_reg[NB-1]) &&
                      (sum_reg[NB-1][WIDTH-1] != a_msb_reg[NB-1]);

endmodule

// File: tb/tb_carry_select_pipe.sv
module tb_carry_select_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 16-bit, 4-bit blocks (latency 4)
   logic        clr16, iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
   logic [15:0] a16, b16, s16;
   // 4-bit, single block (latency 1)
   logic        clr4, iv4, ir4, cin4, sub4, ov4, or4, co4, of4;
   logic [3:0]  a4, b4, s4;
   // 12-bit, 3-bit blocks (latency 4)
   logic        clr12, iv12, ir12, cin12, sub12, ov12, or12, co12, of12;
   logic [11:0] a12, b12, s12;

   carry_select_pipe #(.WIDTH(16), .BLK(4)) dut16 (
      .clk(clk), .rst(rst), .clr(clr16), .in_valid(iv16), .in_ready(ir16),
      .in_a(a16), .in_b(b16), .in_cin(cin16), .in_sub(sub16),
      .out_valid(ov16), .out_ready(or16), .out_sum(s16), .out_cout(co16), .out_ovf(of16));

   carry_select_pipe #(.WIDTH(4), .BLK(4)) dut4 (
      .clk(clk), .rst(rst), .clr(clr4), .in_valid(iv4), .in_ready(ir4),
      .in_a(a4), .in_b(b4), .in_cin(cin4), .in_sub(sub4),
      .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_cout(co4), .out_ovf(of4));

   carry_select_pipe #(.WIDTH(12), .BLK(3)) dut12 (
      .clk(clk), .rst(rst), .clr(clr12), .in_valid(iv12), .in_ready(ir12),
      .in_a(a12), .in_b(b12), .in_cin(cin12), .in_sub(sub12),
      .out_valid(ov12), .out_ready(or12), .out_sum(s12), .out_cout(co12), .out_ovf(of12));

   int pass_cnt = 0;
   int total    = 0;
   int fail_cnt = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit operands.
   // Returns {ovf, cout, sum zero-extended to 16 bits}.
   function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b,
                                         logic cin, logic sub);
      logic [31:0] mask, be, full, s;
      logic        cout, ovf;
      mask = (32'd1 << w) - 32'd1;
      be   = sub ? (~{16'h0, b}) & mask : {16'h0, b};
      full = {16'h0, a} + be + {31'h0, cin};
      s    = full & mask;
      cout = full[w];
      ovf  = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
      return {ovf, cout, s[15:0]};
   endfunction

   // One isolated 16-bit operation: checks acceptance, latency and result.
   task automatic op16(logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                       logic [17:0] exp);
      int lat;
      @(negedge clk);
      a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1; or16 = 1'b1;
      #1 chk("op_ready", {31'h0, ir16}, 32'd1);
      @(posedge clk);
      #1 iv16 = 1'b0;
      lat = 0;
      while (!ov16 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("op_latency", lat, 32'd4);
      chk("op_result", {14'h0, of16, co16, s16}, {14'h0, exp});
      $display("op16 a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               a, b, cin, sub, s16, co16, of16, lat);
   endtask

   logic [17:0] q16[$], q4[$], q12[$];
   logic [17:0] exp, held;
   logic        stalled, need_new;
   int          sent, got, cyc, n4, g4, n12, g12;

   initial begin
      rst = 1'b1;
      {clr16, iv16, cin16, sub16, or16, a16, b16} = '0;
      {clr4, iv4, cin4, sub4, or4, a4, b4} = '0;
      {clr12, iv12, cin12, sub12, or12, a12, b12} = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'h0, ov16}, 32'd0);
      chk("rst_outs", {14'h0, of16, co16, s16}, 32'd0);
      chk("rst_ready", {31'h0, ir16}, 32'd1);
      rst = 1'b0;

      // Directed cases
      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
      op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
      op16(16'h8000, 16'hFFFF, 1'b0, 1'b0, {1'b1, 1'b1, 16'h7FFF});
      op16(16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002});
      op16(16'h0003, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      op16(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});

      // Streaming with random back-pressure
      sent = 0; got = 0; cyc = 0; stalled = 1'b0; need_new = 1'b1; held = '0;
      while (got < 20 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            chk("stall_valid", {31'h0, ov16}, 32'd1);
            chk("stall_hold", {14'h0, of16, co16, s16}, {14'h0, held});
         end
         if (sent < 20) begin
            if (need_new) begin
               a16 = 16'($urandom); b16 = 16'($urandom);
               cin16 = 1'($urandom); sub16 = 1'($urandom);
            end
            iv16 = 1'b1;
         end else begin
            iv16 = 1'b0;
         end
         or16 = 1'($urandom);
         #1;
         chk("ready_rule", {31'h0, ir16}, {31'h0, !(ov16 && !or16)});
         if (ov16 && or16) begin
            chk("stream_nonempty", {31'h0, q16.size() > 0}, 32'd1);
            exp = (q16.size() > 0) ? q16.pop_front() : 18'h0;
            chk("stream_res", {14'h0, of16, co16, s16}, {14'h0, exp});
            $display("stream #%0d sum=%h cout=%b ovf=%b exp=%h", got, s16, co16, of16, exp);
            got++;
         end
         if (iv16 && ir16) begin
            q16.push_back(model(16, a16, b16, cin16, sub16));
            sent++;
            need_new = 1'b1;
         end else begin
            need_new = 1'b0;
         end
         stalled = ov16 && !or16;
         held = {of16, co16, s16};
      end
      chk("stream_count", got, 32'd20);
      iv16 = 1'b0; or16 = 1'b1;

      // Flush: three ops in flight, clr (with a discarded offer) for one cycle
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1'b1;
         @(negedge clk);
      end
      clr16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
      @(negedge clk);
      clr16 = 1'b0; iv16 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("flush_quiet", {31'h0, ov16}, 32'd0);
         @(negedge clk);
      end
      $display("flush done");
      op16(16'h1234, 16'h4321, 1'b1, 1'b0, model(16, 16'h1234, 16'h4321, 1'b1, 1'b0));

      // Reset while the pipe is full and stalled
      @(negedge clk);
      or16 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a16 = 16'h1234 + 16'(i); b16 = 16'h1111; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
         @(negedge clk);
      end
      iv16 = 1'b0;
      chk("full_valid", {31'h0, ov16}, 32'd1);
      chk("full_sum", {16'h0, s16}, 32'h2345);
      chk("full_ready", {31'h0, ir16}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", {31'h0, ov16}, 32'd0);
      chk("async_outs", {14'h0, of16, co16, s16}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_ready", {31'h0, ir16}, 32'd1);
      repeat (5) @(negedge clk);
      chk("post_rst_quiet", {31'h0, ov16}, 32'd0);
      $display("reset mid-op done");
      op16(16'h8000, 16'h8000, 1'b0, 1'b0, model(16, 16'h8000, 16'h8000, 1'b0, 1'b0));

      // 4-bit exhaustive and 12-bit random, streaming side by side
      n4 = 0; g4 = 0; n12 = 0; g12 = 0;
      or4 = 1'b1; or12 = 1'b1;
      for (int c = 0; c < 1100; c++) begin
         @(negedge clk);
         if (n4 < 1024) begin
            {a4, b4, cin4, sub4} = 10'(n4);
            iv4 = 1'b1;
         end else iv4 = 1'b0;
         if (n12 < 1000) begin
            a12 = 12'($urandom); b12 = 12'($urandom);
            cin12 = 1'($urandom); sub12 = 1'($urandom);
            iv12 = 1'b1;
         end else iv12 = 1'b0;
         #1;
         if (ov4) begin
            chk("w4_nonempty", {31'h0, q4.size() > 0}, 32'd1);
            exp = (q4.size() > 0) ? q4.pop_front() : 18'h0;
            chk("w4_res", {14'h0, of4, co4, 12'h0, s4}, {14'h0, exp});
            g4++;
         end
         if (ov12) begin
            chk("w12_nonempty", {31'h0, q12.size() > 0}, 32'd1);
            exp = (q12.size() > 0) ? q12.pop_front() : 18'h0;
            chk("w12_res", {14'h0, of12, co12, 4'h0, s12}, {14'h0, exp});
            g12++;
         end
         if (iv4 && ir4) begin
            q4.push_back(model(4, {12'h0, a4}, {12'h0, b4}, cin4, sub4));
            n4++;
         end
         if (iv12 && ir12) begin
            q12.push_back(model(12, {4'h0, a12}, {4'h0, b12}, cin12, sub12));
            n12++;
         end
      end
      chk("w4_count", g4, 32'd1024);
      chk("w12_count", g12, 32'd1000);
      $display("w4 ops=%0d w12 ops=%0d", g4, g12);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/carry_select_pipe.md
# carry_select_pipe

Parametrised, pipelined carry-select adder/subtractor with valid/ready streaming. Generalises the 8-bit two-block carry-select adder to WIDTH bits in BLK-bit blocks, adds a subtract mode, signed-overflow reporting and one pipeline stage per block, so that a new operation can be accepted every cycle. It is the datapath adder for the streaming arithmetic units and is characterised against the ripple and combinational carry-select adders.

## Interface
- WIDTH, 16: operand and sum width. Must be a multiple of BLK.
- BLK, 4: carry-select block width. NB = WIDTH/BLK ≥ 1 is the number of blocks and the latency.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush: clears every stage valid bit; data is don't-care.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (subtract: 1 = no borrow).
- in_sub  in  1  0 = A+B+cin; 1 = A+~B+cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB.
- out_ovf  out  1  two's-complement signed overflow.

## Operation
- Effective B: Be = in_sub ? ~in_b : in_b. Effective carry-in = in_cin in both modes (adc/sbc chaining). Result = (in_a + Be + in_cin) mod 2^WIDTH. out_cout = bit WIDTH of the full sum.
- out_ovf = (a[MSB] == Be[MSB]) && (out_sum[MSB] != a[MSB]).
- Stage 1 (on accept): for each block k, register both candidates, {c0_k, s0_k} = A_k + Be_k + 0 and {c1_k, s1_k} = A_k + Be_k + 1, each BLK+1 bits. Block 0 is resolved immediately with in_cin. Also register the block-0 carry, a[MSB] and Be[MSB].
- Stage s (2..NB): resolves block s-1. sum_k = carry ? s1_k : s0_k and next carry = carry ? c1_k : c0_k, with carry taken from the stage s-1 register. Unresolved candidates and already-resolved sum bits shift forward unchanged.
- Stage NB register drives out_sum, out_cout and out_ovf. When NB = 1, stage 1 is the output stage.
- No combinational path from in_a/in_b to the outputs. Per-stage carry chain ≤ BLK bits plus one mux.
- Flow control is a global stall: en = !out_valid || out_ready. in_ready = en. All stages advance together when en is high. Bubbles are not collapsed; the valid bit travels with its data.
- Stage valid v1 <= in_valid && in_ready. v_s <= v_{s-1}. out_valid = v_NB. Registers hold when en is low.
- clr: all valid bits go to 0 on the next edge, regardless of en. The accept in that cycle is discarded. in_ready is still driven from en.
- rst: all valid bits, out_sum, out_cout and out_ovf go to 0 immediately. Internal data registers are reset to 0. Reset mid-operation discards all in-flight ops.

## Timing
- Latency: an op accepted at edge T appears with out_valid = 1 after edge T+NB-1. That is NB cycles from the accept cycle to first visibility; NB = 1 gives the next cycle.
- Throughput: 1 op/cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0, in_ready = 0 and all outputs are held stable until consumed.
- With out_valid = 0, in_ready = 1 even if out_ready = 0, so an empty pipe fills.
- Simultaneous consume and accept in the same cycle is allowed. Ordering is strictly FIFO and no op is lost or duplicated.
- clr takes priority over accept and advance. rst overrides everything asynchronously.
- Values after reset: out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, in_ready = 1.

## Test plan
- WIDTH=16, BLK=4, add: 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0. out_valid rises exactly 4 cycles after the accept cycle.
- Signed overflow: 0x7FFF + 0x0001 -> 0x8000, cout=0, ovf=1. 0x8000 + 0xFFFF -> 0x7FFF, cout=1, ovf=1.
- Subtract: 0x0005 - 0x0003, sub=1, cin=1 -> 0x0002, cout=1, ovf=0. 0x0003 - 0x0005 -> 0xFFFE, cout=0. 0x8000 - 0x0001 -> 0x7FFF, ovf=1.
- Streaming: 20 back-to-back random ops with out_ready toggled pseudo-randomly. All 20 results match the model in order, in_ready = 0 exactly when out_valid && !out_ready, and outputs are stable during stalls.
- Flush/reset: 3 ops in flight, assert clr for 1 cycle -> no outputs appear for them and the next accepted op emerges after NB cycles. Repeat with rst mid-op -> outputs drop to 0 asynchronously and in_ready = 1 after release.
- Degenerate and odd configs: WIDTH=4, BLK=4 (latency 1) exhaustive over a, b, cin and sub. WIDTH=12, BLK=3 with 1000 random ops checked against a behavioural model.
